// File: rtl/ux607_pwm_arb_pkg.sv
// ---------------------------------------------------------------------------
// ux607_pwm_arb_pkg
// Shared types and constants for the two-master ICB arbiter that sits in
// front of ux607_pwm16_top.
//   arb_state_e : arbiter FSM encoding (IDLE / CMD / RSP)
//   MST0, MST1  : master identifiers used for grant and round-robin pointer
// ---------------------------------------------------------------------------
package ux607_pwm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RSP  = 2'd2
   } arb_state_e;

   localparam logic MST0 = 1'b0;
   localparam logic MST1 = 1'b1;

endpackage

// File: rtl/ux607_rr_arb2.sv
// ---------------------------------------------------------------------------
// ux607_rr_arb2
// Two-way round-robin picker. Purely combinational.
//   req[1:0] in  : request per master
//   ptr      in  : preferred master; wins whenever it requests
//   gnt[1:0] out : one-hot grant, all zero when nobody requests
//   gnt_id   out : index of the winner (equals ptr when nobody requests)
// ---------------------------------------------------------------------------
module ux607_rr_arb2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt_id = ptr;
      // The non-preferred master only wins when the preferred one is silent.
      if (!req[ptr] && req[~ptr]) begin
         gnt_id = ~ptr;
      end
      gnt = 2'b00;
      if (|req) begin
         gnt[gnt_id] = 1'b1;
      end
   end

endmodule

// File: rtl/ux607_pwm16_icb_arb.sv
// ---------------------------------------------------------------------------
// ux607_pwm16_icb_arb
// Lets two ICB masters share the ux607_pwm16_top register port. One master
// is granted at a time (round robin), only one transaction is outstanding,
// and the response is steered back to the granted master.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   m0_icb_cmd_*          : master 0 command (valid/ready, addr, read, wdata)
//   m0_icb_rsp_*          : master 0 response (valid/ready, rdata)
//   m1_icb_*              : same set for master 1
//   s_icb_cmd_*           : command toward ux607_pwm16_top
//   s_icb_rsp_*           : response from ux607_pwm16_top
//   busy                  : FSM is in CMD or RSP
//   grant_id              : current or last granted master
//   dbg_state, dbg_rr_ptr : FSM state and round-robin pointer, for observation
//
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready are both high at the clock edge; valid must hold with stable
// payload until that edge. Command issue and response return are both
// combinational through this block, so ready/valid toward a master depend
// on the slave in the same cycle and must not be looped back combinationally.
// ---------------------------------------------------------------------------
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

module ux607_pwm16_icb_arb
   import ux607_pwm_arb_pkg::*;
#(
   parameter int PA_SIZE = `UX607_PA_SIZE
) (
   input  logic               clk,
   input  logic               reset,

   input  logic               m0_icb_cmd_valid,
   output logic               m0_icb_cmd_ready,
   input  logic [PA_SIZE-1:0] m0_icb_cmd_addr,
   input  logic               m0_icb_cmd_read,
   input  logic [31:0]        m0_icb_cmd_wdata,
   output logic               m0_icb_rsp_valid,
   input  logic               m0_icb_rsp_ready,
   output logic [31:0]        m0_icb_rsp_rdata,

   input  logic               m1_icb_cmd_valid,
   output logic               m1_icb_cmd_ready,
   input  logic [PA_SIZE-1:0] m1_icb_cmd_addr,
   input  logic               m1_icb_cmd_read,
   input  logic [31:0]        m1_icb_cmd_wdata,
   output logic               m1_icb_rsp_valid,
   input  logic               m1_icb_rsp_ready,
   output logic [31:0]        m1_icb_rsp_rdata,

   output logic               s_icb_cmd_valid,
   input  logic               s_icb_cmd_ready,
   output logic [PA_SIZE-1:0] s_icb_cmd_addr,
   output logic               s_icb_cmd_read,
   output logic [31:0]        s_icb_cmd_wdata,
   input  logic               s_icb_rsp_valid,
   output logic               s_icb_rsp_ready,
   input  logic [31:0]        s_icb_rsp_rdata,

   output logic               busy,
   output logic               grant_id,
   output logic [1:0]         dbg_state,
   output logic               dbg_rr_ptr
);

   arb_state_e state_q, state_d;
   logic       grant_q, grant_d;
   logic       rr_ptr_q, rr_ptr_d;

   logic [1:0] arb_gnt;
   logic       arb_id;
   logic       any_req;
   logic       sel;
   logic       sel_cmd_valid;
   logic       sel_rsp_ready;
   logic       cmd_hs;
   logic       rsp_hs;

   ux607_rr_arb2 u_rr_arb2 (
      .req    ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
      .ptr    (rr_ptr_q),
      .gnt    (arb_gnt),
      .gnt_id (arb_id)
   );

   assign any_req = |arb_gnt;

   // In IDLE the live arbitration result steers the muxes so a command can
   // issue in the same cycle it is requested; afterwards the latched grant
   // holds the path until the response completes.
   assign sel           = (state_q == IDLE) ? arb_id : grant_q;
   assign sel_cmd_valid = (sel == MST1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign sel_rsp_ready = (sel == MST1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
   assign cmd_hs        = sel_cmd_valid & s_icb_cmd_ready;
   assign rsp_hs        = s_icb_rsp_valid & sel_rsp_ready;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= MST0;
         rr_ptr_q <= MST0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d = arb_id;
               state_d = cmd_hs ? RSP : CMD;
            end
         end
         CMD: begin
            if (cmd_hs) begin
               state_d = RSP;
            end
         end
         RSP: begin
            if (rsp_hs) begin
               state_d  = IDLE;
               // Prefer the other master next time, whether or not it asked.
               rr_ptr_d = ~grant_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic. Gated by reset so everything reads zero while reset is
   // asserted, even though IDLE would otherwise pass requests straight through.
   always_comb begin
      m0_icb_cmd_ready = 1'b0;
      m1_icb_cmd_ready = 1'b0;
      m0_icb_rsp_valid = 1'b0;
      m1_icb_rsp_valid = 1'b0;
      m0_icb_rsp_rdata = 32'h0;
      m1_icb_rsp_rdata = 32'h0;
      s_icb_cmd_valid  = 1'b0;
      s_icb_cmd_addr   = '0;
      s_icb_cmd_read   = 1'b0;
      s_icb_cmd_wdata  = 32'h0;
      s_icb_rsp_ready  = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE, CMD: begin
               s_icb_cmd_valid = sel_cmd_valid;
               s_icb_cmd_addr  = (sel == MST1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
               s_icb_cmd_read  = (sel == MST1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
               s_icb_cmd_wdata = (sel == MST1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
               // In IDLE nobody is granted until somebody asks; in CMD the
               // locked master keeps ready even if it wrongly drops valid.
               if ((state_q == CMD) || any_req) begin
                  if (sel == MST1) begin
                     m1_icb_cmd_ready = s_icb_cmd_ready;
                  end else begin
                     m0_icb_cmd_ready = s_icb_cmd_ready;
                  end
               end
            end
            RSP: begin
               s_icb_rsp_ready = sel_rsp_ready;
               if (sel == MST1) begin
                  m1_icb_rsp_valid = s_icb_rsp_valid;
                  m1_icb_rsp_rdata = s_icb_rsp_rdata;
               end else begin
                  m0_icb_rsp_valid = s_icb_rsp_valid;
                  m0_icb_rsp_rdata = s_icb_rsp_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered decodes; reset clears the registers asynchronously, so no
   // extra gating is needed here.
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;
   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_ux607_pwm16_icb_arb.sv
// ---------------------------------------------------------------------------
// tb_ux607_pwm16_icb_arb
// Drives both masters and plays the slave. Expected commands and responses
// are queued when stimulus is issued; negedge monitors pop and compare them.
// The reference model keeps a pending flag and payload per master plus the
// preferred-master index, and picks winners from those alone.
// ---------------------------------------------------------------------------
module tb_ux607_pwm16_icb_arb;

   logic        clk;
   logic        rst;

   logic [1:0]  m_cmd_valid;
   logic [1:0]  m_cmd_ready;
   logic [1:0]  m_cmd_read;
   logic [31:0] m_cmd_addr  [2];
   logic [31:0] m_cmd_wdata [2];
   logic [1:0]  m_rsp_valid;
   logic [1:0]  m_rsp_ready;
   logic [31:0] m_rsp_rdata [2];

   logic        s_icb_cmd_valid;
   logic        s_icb_cmd_ready;
   logic [31:0] s_icb_cmd_addr;
   logic        s_icb_cmd_read;
   logic [31:0] s_icb_cmd_wdata;
   logic        s_icb_rsp_valid;
   logic        s_icb_rsp_ready;
   logic [31:0] s_icb_rsp_rdata;

   logic        busy;
   logic        grant_id;
   logic [1:0]  dbg_state;
   logic        dbg_rr_ptr;

   // Reference model state
   bit          pend    [2];
   logic [31:0] p_addr  [2];
   logic        p_read  [2];
   logic [31:0] p_wdata [2];
   int          ptr;

   // Scoreboards: {id, addr, read, wdata} and {id, rdata}
   logic [65:0] exp_cmd_q[$];
   logic [32:0] exp_rsp_q[$];

   int n_chk;
   int n_fail;

   ux607_pwm16_icb_arb #(.PA_SIZE(32)) dut (
      .clk              (clk),
      .reset            (rst),
      .m0_icb_cmd_valid (m_cmd_valid[0]),
      .m0_icb_cmd_ready (m_cmd_ready[0]),
      .m0_icb_cmd_addr  (m_cmd_addr[0]),
      .m0_icb_cmd_read  (m_cmd_read[0]),
      .m0_icb_cmd_wdata (m_cmd_wdata[0]),
      .m0_icb_rsp_valid (m_rsp_valid[0]),
      .m0_icb_rsp_ready (m_rsp_ready[0]),
      .m0_icb_rsp_rdata (m_rsp_rdata[0]),
      .m1_icb_cmd_valid (m_cmd_valid[1]),
      .m1_icb_cmd_ready (m_cmd_ready[1]),
      .m1_icb_cmd_addr  (m_cmd_addr[1]),
      .m1_icb_cmd_read  (m_cmd_read[1]),
      .m1_icb_cmd_wdata (m_cmd_wdata[1]),
      .m1_icb_rsp_valid (m_rsp_valid[1]),
      .m1_icb_rsp_ready (m_rsp_ready[1]),
      .m1_icb_rsp_rdata (m_rsp_rdata[1]),
      .s_icb_cmd_valid  (s_icb_cmd_valid),
      .s_icb_cmd_ready  (s_icb_cmd_ready),
      .s_icb_cmd_addr   (s_icb_cmd_addr),
      .s_icb_cmd_read   (s_icb_cmd_read),
      .s_icb_cmd_wdata  (s_icb_cmd_wdata),
      .s_icb_rsp_valid  (s_icb_rsp_valid),
      .s_icb_rsp_ready  (s_icb_rsp_ready),
      .s_icb_rsp_rdata  (s_icb_rsp_rdata),
      .busy             (busy),
      .grant_id         (grant_id),
      .dbg_state        (dbg_state),
      .dbg_rr_ptr       (dbg_rr_ptr)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_cmd_ready"}, {30'd0, m_cmd_ready}, 32'h0);
      chk({tag, "_rsp_valid"}, {30'd0, m_rsp_valid}, 32'h0);
      chk({tag, "_m0_rdata"}, m_rsp_rdata[0], 32'h0);
      chk({tag, "_m1_rdata"}, m_rsp_rdata[1], 32'h0);
      chk({tag, "_s_cmd_valid"}, s_icb_cmd_valid, 32'h0);
      chk({tag, "_s_rsp_ready"}, s_icb_rsp_ready, 32'h0);
      chk({tag, "_busy"}, busy, 32'h0);
      chk({tag, "_grant_id"}, grant_id, 32'h0);
   endtask

   task automatic clear_inputs();
      m_cmd_valid     = 2'b00;
      m_cmd_read      = 2'b00;
      m_rsp_ready     = 2'b00;
      s_icb_cmd_ready = 1'b0;
      s_icb_rsp_valid = 1'b0;
      s_icb_rsp_rdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         m_cmd_addr[i]  = 32'h0;
         m_cmd_wdata[i] = 32'h0;
         pend[i]        = 1'b0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic post_req(input int i, input logic [31:0] a, input logic r, input logic [31:0] d);
      pend[i]        = 1'b1;
      p_addr[i]      = a;
      p_read[i]      = r;
      p_wdata[i]     = d;
      m_cmd_valid[i] = 1'b1;
      m_cmd_addr[i]  = a;
      m_cmd_read[i]  = r;
      m_cmd_wdata[i] = d;
   endtask

   // Serves one transaction for whichever master the model says wins.
   // Called just after a rising edge with the requests already driven.
   task automatic do_round(input int cmd_dly, input int rsp_dly, input logic [31:0] rdata, input bit late);
      int   w;
      int   n;
      logic wb;
      w  = pend[ptr] ? ptr : 1 - ptr;
      wb = w[0];
      exp_cmd_q.push_back({wb, p_addr[w], p_read[w], p_wdata[w]});
      s_icb_cmd_ready = (cmd_dly == 0);
      n = 0;
      forever begin
         @(negedge clk);
         if (s_icb_cmd_valid && s_icb_cmd_ready) break;
         chk("hold_cmd_valid", s_icb_cmd_valid, 32'h1);
         chk("hold_cmd_addr", s_icb_cmd_addr, p_addr[w]);
         chk("hold_cmd_wdata", s_icb_cmd_wdata, p_wdata[w]);
         chk("hold_loser_ready", m_cmd_ready[1-w], 32'h0);
         @(posedge clk); #1;
         n++;
         if (late && n == 1 && !pend[1-w]) begin
            post_req(1 - w, $urandom, 1'($urandom_range(0, 1)), $urandom);
         end
         if (n >= cmd_dly) s_icb_cmd_ready = 1'b1;
         if (n > 64) begin
            n_chk++; n_fail++;
            $display("FAIL cmd_timeout: got no command handshake expected one within 64 cycles");
            return;
         end
      end
      @(posedge clk); #1;
      m_cmd_valid[w]  = 1'b0;
      pend[w]         = 1'b0;
      s_icb_cmd_ready = 1'b0;
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_rdata = rdata;
      exp_rsp_q.push_back({wb, rdata});
      m_rsp_ready[w]   = (rsp_dly == 0);
      m_rsp_ready[1-w] = 1'($urandom_range(0, 1));
      n = 0;
      forever begin
         @(negedge clk);
         if (m_rsp_valid[w] && m_rsp_ready[w]) break;
         chk("hold_rsp_valid", m_rsp_valid[w], 32'h1);
         chk("hold_rsp_rdata", m_rsp_rdata[w], rdata);
         chk("hold_other_rsp_valid", m_rsp_valid[1-w], 32'h0);
         chk("hold_no_cmd_ready", {30'd0, m_cmd_ready}, 32'h0);
         @(posedge clk); #1;
         n++;
         if (n >= rsp_dly) m_rsp_ready[w] = 1'b1;
         if (n > 64) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: got no response handshake expected one within 64 cycles");
            return;
         end
      end
      @(posedge clk); #1;
      s_icb_rsp_valid = 1'b0;
      m_rsp_ready     = 2'b00;
      ptr             = 1 - w;
      chk("rr_ptr_after", dbg_rr_ptr, ptr);
      chk("state_after", dbg_state, 32'h0);
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (s_icb_cmd_valid && s_icb_cmd_ready) begin
            if (exp_cmd_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL cmd_unexpected: got command addr %h expected none", s_icb_cmd_addr);
            end else begin
               logic [65:0] e;
               logic        w;
               e = exp_cmd_q.pop_front();
               w = e[65];
               chk("cmd_addr", s_icb_cmd_addr, e[64:33]);
               chk("cmd_read", s_icb_cmd_read, e[32]);
               chk("cmd_wdata", s_icb_cmd_wdata, e[31:0]);
               chk("winner_ready", m_cmd_ready[w], 32'h1);
               chk("loser_ready", m_cmd_ready[~w], 32'h0);
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (m_rsp_valid[i] && m_rsp_ready[i]) begin
               if (exp_rsp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL rsp_unexpected: got response on m%0d expected none", i);
               end else begin
                  logic [32:0] r;
                  r = exp_rsp_q.pop_front();
                  chk("rsp_id", i, r[32]);
                  chk("rsp_rdata", m_rsp_rdata[i], r[31:0]);
                  chk("other_rsp_valid", m_rsp_valid[1-i], 32'h0);
                  chk("other_rsp_rdata", m_rsp_rdata[1-i], 32'h0);
                  chk("rsp_busy", busy, 32'h1);
                  chk("rsp_grant_id", grant_id, i);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      n_chk  = 0;
      n_fail = 0;
      ptr    = 0;
      clear_inputs();
      rst = 1'b1;
      // Everything requesting while in reset: outputs must still read zero.
      m_cmd_valid     = 2'b11;
      m_rsp_ready     = 2'b11;
      s_icb_cmd_ready = 1'b1;
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_rdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #2;
      check_all_zero("in_reset");
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_state", dbg_state, 32'h0);
      chk("post_reset_rr_ptr", dbg_rr_ptr, 32'h0);
      chk("post_reset_busy", busy, 32'h0);
      @(posedge clk); #1;

      // Simultaneous reads: m0, then m1, then m0 again on a fresh tie.
      post_req(0, $urandom, 1'b1, $urandom);
      post_req(1, $urandom, 1'b1, $urandom);
      do_round(0, 0, $urandom, 1'b0);
      do_round(0, 1, $urandom, 1'b0);
      post_req(0, $urandom, 1'b1, $urandom);
      post_req(1, $urandom, 1'b1, $urandom);
      do_round(0, 0, $urandom, 1'b0);
      do_round(0, 0, $urandom, 1'b0);

      // Lone m0 write, zero-wait slave: pointer moves to m1.
      post_req(0, 32'h0000_0010, 1'b0, 32'h0000_00FF);
      do_round(0, 0, $urandom, 1'b0);

      // Slave stalls 3 cycles while m1 shows up late behind the m0 grant.
      post_req(0, $urandom, 1'b0, $urandom);
      do_round(3, 0, $urandom, 1'b1);
      do_round(1, 1, $urandom, 1'b0);

      // m0 stalls its response 4 cycles while m1 keeps requesting.
      post_req(0, $urandom, 1'b1, $urandom);
      post_req(1, $urandom, 1'b1, $urandom);
      do_round(0, 4, 32'hDEAD_BEEF, 1'b0);
      do_round(0, 0, $urandom, 1'b0);

      // Randomized traffic.
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               post_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
            end
         end
         if (!pend[0] && !pend[1]) begin
            post_req(int'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
         end
         do_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
      end
      while (pend[0] || pend[1]) begin
         do_round(0, 0, $urandom, 1'b0);
      end

      // Reset in RSP abandons the transaction; a fresh m1 request then wins.
      post_req(0, $urandom, 1'b1, $urandom);
      exp_cmd_q.push_back({1'b0, p_addr[0], p_read[0], p_wdata[0]});
      s_icb_cmd_ready = 1'b1;
      @(posedge clk); #1;
      m_cmd_valid[0]  = 1'b0;
      pend[0]         = 1'b0;
      s_icb_cmd_ready = 1'b0;
      post_req(1, $urandom, 1'b0, $urandom);
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_rdata = $urandom;
      m_rsp_ready     = 2'b00;
      @(negedge clk);
      chk("pre_reset_busy", busy, 32'h1);
      chk("pre_reset_state", dbg_state, 32'h2);
      #1 rst = 1'b1;
      #1 check_all_zero("reset_in_rsp");
      clear_inputs();
      ptr = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rerun_state", dbg_state, 32'h0);
      chk("rerun_rr_ptr", dbg_rr_ptr, 32'h0);
      @(posedge clk); #1;
      post_req(1, $urandom, 1'b1, $urandom);
      do_round(0, 0, $urandom, 1'b0);

      repeat (2) @(posedge clk);
      chk("cmd_queue_empty", exp_cmd_q.size(), 32'h0);
      chk("rsp_queue_empty", exp_rsp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
